// File: rtl/shift_reg_univ_ce.sv
// Universal shift register with hold, shift, rotate, load and clear modes.
// It steps only on ticks from an internal clock-enable divider, so it needs no derived clock.
module shift_reg_univ_ce #(
  parameter int                 WIDTH   = 8,
  parameter int                 DIV     = 50000000,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [2:0]       MODE,
  input  logic             SER,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             SO_R,
  output logic             SO_L,
  output logic             TICK
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  typedef enum logic [2:0] {
    M_HOLD  = 3'b000,
    M_SHR   = 3'b001,
    M_SHL   = 3'b010,
    M_ROR   = 3'b011,
    M_ROL   = 3'b100,
    M_LOAD  = 3'b101,
    M_CLEAR = 3'b110,
    M_RSVD  = 3'b111
  } mode_e;

  logic [CW-1:0]    cnt;
  logic             cnt_last;
  logic [WIDTH-1:0] q_next;
  mode_e            mode;

  assign cnt_last = (cnt == LAST);
  assign mode     = mode_e'(MODE);

  // Counting every edge and wrapping at DIV-1 keeps the tick spacing exact.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (cnt_last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Gated with RST so that a DIV=1 divider does not report a tick while in reset.
  assign TICK = cnt_last & ~RST;

  always_comb begin
    q_next = Q;
    case (mode)
      M_SHR:   q_next = {SER, Q[WIDTH-1:1]};
      M_SHL:   q_next = {Q[WIDTH-2:0], SER};
      M_ROR:   q_next = {Q[0], Q[WIDTH-1:1]};
      M_ROL:   q_next = {Q[WIDTH-2:0], Q[WIDTH-1]};
      M_LOAD:  q_next = D;
      M_CLEAR: q_next = '0;
      default: q_next = Q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Q <= RST_VAL;
    end else if (cnt_last) begin
      Q <= q_next;
    end
  end

  // Outgoing bits come straight from Q so a cascaded stage sees them before the shared tick.
  assign SO_R = Q[0];
  assign SO_L = Q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_univ_ce.sv
// Directed bench for shift_reg_univ_ce: three instances cover DIV=4, DIV=1 and a 16-bit DIV=3 build.
module tb_shift_reg_univ_ce;

  logic        clk;
  logic        rst_a, rst_b, rst_c;
  logic [2:0]  mode;
  logic        ser;
  logic [15:0] d;

  logic [7:0]  q_a, q_b;
  logic [15:0] q_c;
  logic        so_r_a, so_l_a, tick_a;
  logic        so_r_b, so_l_b, tick_b;
  logic        so_r_c, so_l_c, tick_c;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_a;

  shift_reg_univ_ce #(.WIDTH(8), .DIV(4), .RST_VAL(8'hA5)) dut_a (
    .CLK(clk), .RST(rst_a), .MODE(mode), .SER(ser), .D(d[7:0]),
    .Q(q_a), .SO_R(so_r_a), .SO_L(so_l_a), .TICK(tick_a)
  );

  shift_reg_univ_ce #(.WIDTH(8), .DIV(1), .RST_VAL(8'h00)) dut_b (
    .CLK(clk), .RST(rst_b), .MODE(mode), .SER(ser), .D(d[7:0]),
    .Q(q_b), .SO_R(so_r_b), .SO_L(so_l_b), .TICK(tick_b)
  );

  shift_reg_univ_ce #(.WIDTH(16), .DIV(3), .RST_VAL(16'h0000)) dut_c (
    .CLK(clk), .RST(rst_c), .MODE(mode), .SER(ser), .D(d),
    .Q(q_c), .SO_R(so_r_c), .SO_L(so_l_c), .TICK(tick_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic edge_a();
    @(posedge clk);
    #1;
  endtask

  // One full DIV=4 period on instance a: junk inputs on the three idle edges, real inputs at the tick edge.
  task automatic run_a(input logic [2:0] m, input logic s, input logic [7:0] dv,
                       input logic [7:0] exp_new, input string tag);
    for (int i = 0; i < 3; i++) begin
      mode = 3'($urandom_range(0, 7));
      ser  = 1'($urandom_range(0, 1));
      d    = 16'($urandom);
      edge_a();
      check({tag, "_hold"}, {8'h00, q_a}, {8'h00, exp_a});
      check({tag, "_tick"}, {15'd0, tick_a}, {15'd0, (i == 2)});
    end
    mode = m;
    ser  = s;
    d    = {8'h00, dv};
    edge_a();
    exp_a = exp_new;
    check({tag, "_q"}, {8'h00, q_a}, {8'h00, exp_new});
    check({tag, "_tick_low"}, {15'd0, tick_a}, 16'd0);
    check({tag, "_so_r"}, {15'd0, so_r_a}, {15'd0, exp_new[0]});
    check({tag, "_so_l"}, {15'd0, so_l_a}, {15'd0, exp_new[7]});
  endtask

  initial begin
    logic [7:0] rol_seq [8];
    logic [7:0] ror_seq [5];
    logic [7:0] fill;

    rol_seq = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
    ror_seq = '{8'h78, 8'h3C, 8'h1E, 8'h0F, 8'h87};

    rst_a = 1'b0;
    rst_b = 1'b1;
    rst_c = 1'b1;
    mode  = 3'b000;
    ser   = 1'b0;
    d     = 16'h0000;

    // Asynchronous reset takes effect before any clock edge.
    #2 rst_a = 1'b1;
    #1;
    check("rst_async_q", {8'h00, q_a}, 16'h00A5);
    check("rst_async_tick", {15'd0, tick_a}, 16'd0);
    edge_a();
    check("rst_held_q", {8'h00, q_a}, 16'h00A5);
    check("rst_held_tick", {15'd0, tick_a}, 16'd0);
    rst_a = 1'b0;
    exp_a = 8'hA5;

    // Tick cadence with MODE=hold.
    run_a(3'b000, 1'b0, 8'h00, 8'hA5, "cad1");
    run_a(3'b000, 1'b1, 8'hFF, 8'hA5, "cad2");

    // Load then shift right with SER=0.
    run_a(3'b101, 1'b0, 8'h81, 8'h81, "ld81");
    run_a(3'b001, 1'b0, 8'hFF, 8'h40, "shr1");
    run_a(3'b001, 1'b0, 8'hFF, 8'h20, "shr2");
    run_a(3'b001, 1'b0, 8'hFF, 8'h10, "shr3");
    run_a(3'b001, 1'b1, 8'h00, 8'h88, "shr_ser1");

    // Rotate left ignores SER.
    run_a(3'b101, 1'b0, 8'h81, 8'h81, "ld81b");
    for (int i = 0; i < 8; i++) begin
      run_a(3'b100, 1'(i), 8'h55, rol_seq[i], $sformatf("rol%0d", i));
    end

    // Shift-left fill, clear (not RST_VAL) and reserved/hold codes.
    run_a(3'b101, 1'b0, 8'h00, 8'h00, "ld00");
    fill = 8'h00;
    for (int i = 0; i < 8; i++) begin
      fill = {fill[6:0], 1'b1};
      run_a(3'b010, 1'b1, 8'h00, fill, $sformatf("shl%0d", i));
    end
    run_a(3'b110, 1'b1, 8'hFF, 8'h00, "clear");
    run_a(3'b111, 1'b1, 8'hFF, 8'h00, "rsvd0");
    run_a(3'b101, 1'b0, 8'h5A, 8'h5A, "ld5a");
    run_a(3'b111, 1'b1, 8'hFF, 8'h5A, "rsvd1");
    run_a(3'b000, 1'b1, 8'hFF, 8'h5A, "hold");

    // Reset two edges into a period: count restarts and the next period is full length.
    mode = 3'b000;
    edge_a();
    check("mid_e1_tick", {15'd0, tick_a}, 16'd0);
    edge_a();
    check("mid_e2_tick", {15'd0, tick_a}, 16'd0);
    rst_a = 1'b1;
    #1;
    check("mid_rst_q", {8'h00, q_a}, 16'h00A5);
    check("mid_rst_tick", {15'd0, tick_a}, 16'd0);
    mode = 3'b101;
    d    = 16'h00FF;
    edge_a();
    check("mid_rst_edge_q", {8'h00, q_a}, 16'h00A5);
    check("mid_rst_edge_tick", {15'd0, tick_a}, 16'd0);
    rst_a = 1'b0;
    exp_a = 8'hA5;
    run_a(3'b101, 1'b0, 8'h3C, 8'h3C, "post_rst");

    // DIV=1: a step on every edge and TICK constantly high out of reset.
    check("b_rst_tick", {15'd0, tick_b}, 16'd0);
    check("b_rst_q", {8'h00, q_b}, 16'h0000);
    rst_b = 1'b0;
    #1;
    check("b_tick_release", {15'd0, tick_b}, 16'd1);
    mode = 3'b101;
    d    = 16'h00F0;
    edge_a();
    check("b_ldf0", {8'h00, q_b}, 16'h00F0);
    mode = 3'b011;
    for (int i = 0; i < 5; i++) begin
      ser = 1'(~i);
      edge_a();
      check($sformatf("b_ror%0d", i), {8'h00, q_b}, {8'h00, ror_seq[i]});
      check($sformatf("b_tick%0d", i), {15'd0, tick_b}, 16'd1);
    end

    // WIDTH=16, DIV=3: reset mid-period, then load FFFF and shift left with SER=0.
    rst_c = 1'b0;
    mode  = 3'b000;
    edge_a();
    check("c_e1_tick", {15'd0, tick_c}, 16'd0);
    rst_c = 1'b1;
    #1;
    check("c_rst_q", q_c, 16'h0000);
    check("c_rst_tick", {15'd0, tick_c}, 16'd0);
    edge_a();
    check("c_rst_edge_q", q_c, 16'h0000);
    rst_c = 1'b0;
    mode  = 3'b101;
    d     = 16'hFFFF;
    edge_a();
    check("c_p1_e1_tick", {15'd0, tick_c}, 16'd0);
    check("c_p1_e1_q", q_c, 16'h0000);
    edge_a();
    check("c_p1_e2_tick", {15'd0, tick_c}, 16'd1);
    check("c_p1_e2_q", q_c, 16'h0000);
    edge_a();
    check("c_ldffff", q_c, 16'hFFFF);
    check("c_so_l", {15'd0, so_l_c}, 16'd1);
    mode = 3'b010;
    ser  = 1'b0;
    edge_a();
    check("c_p2_e1_q", q_c, 16'hFFFF);
    edge_a();
    check("c_p2_e2_tick", {15'd0, tick_c}, 16'd1);
    edge_a();
    check("c_shl", q_c, 16'hFFFE);
    check("c_so_r", {15'd0, so_r_c}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
